// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the chunked adder.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic int nchunk_f(input int width, input int chunk);
        return width / chunk;
    endfunction

    // The slice index needs at least one bit, even when there is only one slice.
    function automatic int idx_w_f(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit adder that exposes the carry into its MSB for overflow detection.
module adder_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             c_msb_o
);

    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};

    generate
        if (CHUNK == 1) begin : g_one_bit
            assign c_msb_o = c_i;
        end else begin : g_multi_bit
            logic [CHUNK-1:0] lo;
            assign lo = {1'b0, a_i[CHUNK-2:0]} + {1'b0, b_i[CHUNK-2:0]}
                      + {{(CHUNK-1){1'b0}}, c_i};
            assign c_msb_o = lo[CHUNK-1];
        end
    endgenerate

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor: one CHUNK-bit slice per cycle, LSB first,
// with a registered carry between slices and valid/ready handshakes on both sides.
module chunked_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int IW     = idx_w_f(NCHUNK);
    localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
            $fatal(1, "chunked_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  sum_q, sum_d, sum_upd;
    logic              cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d, vld_q, vld_d;
    logic [CHUNK-1:0]  sl_s;
    logic              sl_c, sl_cm;

    assign in_ready = (state_q == IDLE) && !reset;

    adder_slice #(.CHUNK(CHUNK)) u_slice (
        .a_i     (a_q[idx_q*CHUNK +: CHUNK]),
        .b_i     (b_q[idx_q*CHUNK +: CHUNK]),
        .c_i     (carry_q),
        .s_o     (sl_s),
        .c_o     (sl_c),
        .c_msb_o (sl_cm)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        vld_d   = vld_q;
        sum_upd = sum_q;
        sum_upd[idx_q*CHUNK +: CHUNK] = sl_s;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    state_d = BUSY;
                    idx_d   = '0;
                    a_d     = a;
                    // Subtract is a + ~b + 1; a borrow-in removes that +1.
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                end
            end
            BUSY: begin
                sum_d   = sum_upd;
                carry_d = sl_c;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    cout_d  = sl_c;
                    ovf_d   = sl_cm ^ sl_c;
                    zero_d  = (sum_upd == '0);
                    vld_d   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            vld_q   <= vld_d;
        end
    end

    // Operand registers carry no control meaning, so they are not reset.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
    end

    assign out_valid = vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Bench for chunked_adder: 32/8, 8/4 and 8/8 instances against an arithmetic reference.
module tb_chunked_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        iv[3], ordy[3], cin_s[3], sub_s[3];
    logic [31:0] a_s[3], b_s[3];
    logic        ir[3], ov[3], cout_s[3], ovf_s[3], zero_s[3];
    logic [31:0] sum0;
    logic [7:0]  sum1, sum2;
    int          n_cmp = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    chunked_adder #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[0]), .b(b_s[0]), .cin(cin_s[0]), .sub(sub_s[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sum0),
        .cout(cout_s[0]), .ovf(ovf_s[0]), .zero(zero_s[0]));

    chunked_adder #(.WIDTH(8), .CHUNK(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .cin(cin_s[1]), .sub(sub_s[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sum1),
        .cout(cout_s[1]), .ovf(ovf_s[1]), .zero(zero_s[1]));

    chunked_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[2][7:0]), .b(b_s[2][7:0]), .cin(cin_s[2]), .sub(sub_s[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sum2),
        .cout(cout_s[2]), .ovf(ovf_s[2]), .zero(zero_s[2]));

    function automatic logic [31:0] rd_sum(input int d);
        case (d)
            0:       return sum0;
            1:       return {24'h0, sum1};
            default: return {24'h0, sum2};
        endcase
    endfunction

    function automatic int width_of(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic int nchunk_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 2 : 1;
    endfunction

    // Reference: plain integer arithmetic on the operands, unsigned and signed views.
    task automatic ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                             input logic cin, input logic sub,
                             output logic [31:0] s, output logic c, output logic v, output logic z);
        longint ua, ub, full, sa, sb, r, span, half;
        span = longint'(1) << w;
        half = longint'(1) << (w - 1);
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= half) ? ua - span : ua;
        sb = (ub >= half) ? ub - span : ub;
        if (!sub) begin
            full = ua + ub + longint'(cin);
            c    = (full >= span);
            r    = sa + sb + longint'(cin);
        end else begin
            full = ua - ub - longint'(cin);
            c    = (full >= 0);
            r    = sa - sb - longint'(cin);
        end
        s = 32'(full & (span - 1));
        v = (r >= half) || (r < -half);
        z = (s == 32'h0);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int d, input logic [31:0] a_in, input logic [31:0] b_in,
                      input logic cin, input logic sub, input int stall, input bit poke);
        logic [31:0] mask, a, b, es, held;
        logic        ec, ev, ez;
        int          k, lat;
        mask = (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        a = a_in & mask;
        b = b_in & mask;
        k = 0;
        while (!ir[d] && k < 50) begin
            tick();
            k++;
        end
        chk("in_ready_before_op", 32'(ir[d]), 32'd1);
        a_s[d] = a; b_s[d] = b; cin_s[d] = cin; sub_s[d] = sub; iv[d] = 1'b1;
        tick();
        iv[d] = 1'b0;
        a_s[d] = $urandom; b_s[d] = $urandom; cin_s[d] = 1'($urandom); sub_s[d] = 1'($urandom);
        lat = 0;
        while (!ov[d] && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'(nchunk_of(d)));
        ref_model(width_of(d), a, b, cin, sub, es, ec, ev, ez);
        chk("sum", rd_sum(d), es);
        chk("cout", 32'(cout_s[d]), 32'(ec));
        chk("ovf", 32'(ovf_s[d]), 32'(ev));
        chk("zero", 32'(zero_s[d]), 32'(ez));
        held = es;
        for (int i = 0; i < stall; i++) begin
            if (poke) begin
                iv[d] = 1'b1; a_s[d] = $urandom; b_s[d] = $urandom;
            end
            tick();
            chk("hold_sum", rd_sum(d), held);
            chk("hold_flags", {29'h0, cout_s[d], ovf_s[d], zero_s[d]}, {29'h0, ec, ev, ez});
            chk("hold_valid", 32'(ov[d]), 32'd1);
            chk("hold_in_ready", 32'(ir[d]), 32'd0);
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        chk("valid_drop", 32'(ov[d]), 32'd0);
        chk("idle_in_ready", 32'(ir[d]), 32'd1);
        chk("sum_kept", rd_sum(d), held);
    endtask

    initial begin
        logic [31:0] corner[4];
        int k;
        corner[0] = 32'h00; corner[1] = 32'h7F; corner[2] = 32'h80; corner[3] = 32'hFF;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ordy[d] = 1'b0; cin_s[d] = 1'b0; sub_s[d] = 1'b0;
            a_s[d] = '0; b_s[d] = '0;
        end
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", 32'(ov[d]), 32'd0);
            chk("rst_sum", rd_sum(d), 32'd0);
            chk("rst_flags", {29'h0, cout_s[d], ovf_s[d], zero_s[d]}, 32'd0);
            chk("rst_in_ready", 32'(ir[d]), 32'd0);
        end
        reset = 1'b0;
        tick();
        for (int d = 0; d < 3; d++) chk("post_rst_in_ready", 32'(ir[d]), 32'd1);

        op(0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        op(0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, 1'b0);
        op(0, 32'h5, 32'h7, 1'b0, 1'b1, 0, 1'b0);
        op(0, 32'h7, 32'h5, 1'b1, 1'b1, 0, 1'b0);
        op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 10, 1'b1);

        // Abort during the second BUSY cycle.
        a_s[0] = 32'h1111_1111; b_s[0] = 32'h2222_2222; cin_s[0] = 1'b0; sub_s[0] = 1'b0;
        iv[0] = 1'b1;
        tick();
        iv[0] = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("abort_valid", 32'(ov[0]), 32'd0);
        chk("abort_sum", sum0, 32'd0);
        chk("abort_flags", {29'h0, cout_s[0], ovf_s[0], zero_s[0]}, 32'd0);
        chk("abort_in_ready_in_reset", 32'(ir[0]), 32'd0);
        reset = 1'b0;
        tick();
        chk("abort_in_ready_after", 32'(ir[0]), 32'd1);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ov[0]) k++;
        end
        chk("abort_no_valid", 32'(k), 32'd0);
        op(0, 32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0);
        chk("three_plus_four", sum0, 32'd7);

        for (int i = 0; i < 150; i++)
            op(0, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));

        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int c = 0; c < 4; c++)
                    op(1, corner[i], corner[j], c[0], c[1], 0, 1'b0);
        for (int i = 0; i < 2500; i++)
            op(1, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0);

        for (int c = 0; c < 4; c++) op(2, 32'hFF, 32'h01, c[0], c[1], 0, 1'b0);
        for (int i = 0; i < 200; i++)
            op(2, $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom_range(0, 2), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
